// File: rtl/mac_psum_sender.sv
// -----------------------------------------------------------------------------
// mac_psum_sender
//
// Transmit side of the MAC partial-sum stream. fp32 psums produced by the MAC
// array are buffered in a small FIFO and forwarded to mac_psum_accumulator over
// a valid/ready link, tagged with two sideband flags:
//   - inter_end : the word is the last psum of the current pass
//   - accum_end : the word belongs to the final pass of the job
//
// One job = num_pass passes of TILE_LEN psums. A job is configured through a
// cfg valid/ready handshake that is only accepted while idle.
//
// Ports
//   i_clk, i_reset        clock (posedge) and asynchronous active-high reset
//   i_cfg_valid/o_cfg_ready, i_cfg_num_pass
//                         job configuration (num_pass of 0 behaves as 1)
//   i_psum_valid/o_psum_ready, i_psum_data
//                         upstream psum stream from the MAC array
//   o_psum_valid/i_psum_ready, o_psum_data, o_inter_end, o_accum_end
//                         downstream stream to the accumulator
//   o_busy                a job is in progress
//   o_done                one-cycle pulse once the whole job has been sent
// -----------------------------------------------------------------------------
module mac_psum_sender #(
  parameter int DATA_W     = 32,
  parameter int TILE_LEN   = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int PASS_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  // job configuration
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [PASS_W-1:0] i_cfg_num_pass,
  // upstream psums
  input  logic              i_psum_valid,
  output logic              o_psum_ready,
  input  logic [DATA_W-1:0] i_psum_data,
  // downstream psums
  output logic              o_psum_valid,
  input  logic              i_psum_ready,
  output logic [DATA_W-1:0] o_psum_data,
  output logic              o_inter_end,
  output logic              o_accum_end,
  // status
  output logic              o_busy,
  output logic              o_done
);

  localparam int TILE_W = $clog2(TILE_LEN);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  // Wide enough to hold num_pass*TILE_LEN for the largest num_pass.
  localparam int CNT_W  = PASS_W + TILE_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q,    state_d;
  logic [PASS_W-1:0] num_pass_q, num_pass_d;
  logic [CNT_W-1:0]  in_cnt_q,   in_cnt_d;
  logic [TILE_W-1:0] elem_cnt_q, elem_cnt_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [PTR_W:0]    wr_ptr_q,   wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q,   rd_ptr_d;

  // Buffer storage: no reset needed, validity is tracked by the pointers.
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Derived conditions
  // ---------------------------------------------------------------------------
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  job_total;
  logic              in_room;
  logic              psum_ready;
  logic              push;
  logic              pop;
  logic              last_elem;
  logic              last_pass;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // TILE_LEN is a power of two, so num_pass*TILE_LEN is just a shift.
  assign job_total  = {num_pass_q, {TILE_W{1'b0}}};
  assign in_room    = (in_cnt_q < job_total);

  // Readiness deliberately ignores a same-cycle pop: a full buffer blocks the
  // push even while the head is leaving, which keeps this path short.
  assign psum_ready = (state_q == ST_STREAM) && !fifo_full && in_room;

  assign push       = i_psum_valid && psum_ready;
  assign pop        = !fifo_empty && i_psum_ready;

  assign last_elem  = (elem_cnt_q == {TILE_W{1'b1}});
  // num_pass_q is never 0 once a job is running, so the subtraction is safe;
  // after reset the FIFO is empty and the flag is masked anyway.
  assign last_pass  = (pass_cnt_q == (num_pass_q - PASS_W'(1)));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    num_pass_d = num_pass_q;
    in_cnt_d   = in_cnt_q;
    elem_cnt_d = elem_cnt_q;
    pass_cnt_d = pass_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_cfg_valid) begin
          num_pass_d = (i_cfg_num_pass == '0) ? PASS_W'(1) : i_cfg_num_pass;
          in_cnt_d   = '0;
          elem_cnt_d = '0;
          pass_cnt_d = '0;
          state_d    = ST_STREAM;
        end
      end

      ST_STREAM: begin
        if (push) begin
          in_cnt_d = in_cnt_q + CNT_W'(1);
        end
        if (pop) begin
          if (last_elem) begin
            elem_cnt_d = '0;
            pass_cnt_d = pass_cnt_q + PASS_W'(1);
            if (last_pass) begin
              state_d = ST_DONE;
            end
          end else begin
            elem_cnt_d = elem_cnt_q + TILE_W'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The FIFO only ever holds data during STREAM, so pointer updates need no
  // state qualification beyond push/pop themselves.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
    rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      num_pass_q <= '0;
      in_cnt_q   <= '0;
      elem_cnt_q <= '0;
      pass_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      num_pass_q <= num_pass_d;
      in_cnt_q   <= in_cnt_d;
      elem_cnt_q <= elem_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[PTR_W-1:0]] <= i_psum_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Head is read combinationally so a word written at one edge is presented
  // right after it. Sideband flags come from the output-side counters, which
  // only move on a handshake, so they stay aligned with the head word and
  // hold steady through a stall.
  assign o_psum_valid = !fifo_empty;
  assign o_psum_data  = fifo_empty ? '0 : fifo_mem[rd_ptr_q[PTR_W-1:0]];
  assign o_inter_end  = !fifo_empty && last_elem;
  assign o_accum_end  = !fifo_empty && last_pass;

  assign o_psum_ready = psum_ready;
  assign o_cfg_ready  = (state_q == ST_IDLE);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = (state_q == ST_DONE);

endmodule
